// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master arbiter for the single data-RAM port. M0 is the RV32I core and
//   M1 is the DMA/debug master. The grant FSM is registered. Arbitration is
//   round-robin with a burst limit. The owner's request is steered onto the
//   RAM port combinationally. The RAM keeps its synchronous-write,
//   combinational-read behaviour.
//
//   Configuration macro: ARB_FIXED_PRIO_EN
//     defined   - M0 has strict priority; only M1 is burst-limited, and it
//                 yields to a waiting M0 after MAX_BURST beats
//     undefined - round-robin with burst limit for both masters
//
// Parameters
//   ADDR_W     slave word-address width (in-range addr[31:ADDR_W] == 0)
//   DATA_W     data width
//   MAX_BURST  max consecutive beats per owner while the other master waits
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   m0_req/we/addr/wdata     M0 request (held until its beat completes)
//   m0_gnt, m0_rdata         M0 grant (registered) and read data
//   m1_*                     same set for M1
//   s_we/s_addr/s_wdata      RAM write enable, word address, write data
//   s_rdata                  RAM read data
//   busy                     high whenever the arbiter is not idle
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_owner;   // 0: M0 owned last, 1: M1 owned last

  // Owner-relative view of the two masters
  logic              own_sel;     // 0: M0 is owner, 1: M1 is owner
  logic              own_req;
  logic              own_we;
  logic [31:0]       own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              oth_req;
  logic              active;
  logic              in_range;
  logic              may_yield;
  logic              pick_m0;     // winner when both request from IDLE
  logic [DATA_W-1:0] rd_beat;

  always_comb begin
    own_sel   = (state == OWN1);
    own_req   = own_sel ? m1_req   : m0_req;
    own_we    = own_sel ? m1_we    : m0_we;
    own_addr  = own_sel ? m1_addr  : m0_addr;
    own_wdata = own_sel ? m1_wdata : m0_wdata;
    oth_req   = own_sel ? m0_req   : m1_req;
    active    = (state != IDLE) && own_req;
    in_range  = (own_addr[31:ADDR_W] == '0);
`ifdef ARB_FIXED_PRIO_EN
    pick_m0   = 1'b1;
    may_yield = own_sel;
`else
    pick_m0   = last_owner;
    may_yield = 1'b1;
`endif
  end

  // Slave mux: only a granted, requesting owner reaches the RAM port.
  // Out-of-range beats still complete but never write and read back zero.
  always_comb begin
    s_we    = active && own_we && in_range;
    s_addr  = active ? own_addr[ADDR_W-1:0] : '0;
    s_wdata = active ? own_wdata : '0;
    rd_beat = (active && !own_we && in_range) ? s_rdata : '0;
    m0_rdata = (state == OWN0) ? rd_beat : '0;
    m1_rdata = (state == OWN1) ? rd_beat : '0;
    m0_gnt  = (state == OWN0);
    m1_gnt  = (state == OWN1);
    busy    = (state != IDLE);
  end

  // OWN0 and OWN1 share one branch written in owner/other terms; own_sel
  // picks the direction of any handover.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (m0_req && m1_req) begin
            state <= pick_m0 ? OWN0 : OWN1;
          end else if (m0_req) begin
            state <= OWN0;
          end else if (m1_req) begin
            state <= OWN1;
          end
        end
        OWN0, OWN1: begin
          if (own_req) begin
            if (oth_req && (beat_cnt == CNT_MAX) && may_yield) begin
              state      <= own_sel ? OWN0 : OWN1;
              beat_cnt   <= '0;
              last_owner <= own_sel;
            end else if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end else begin
            state      <= oth_req ? (own_sel ? OWN0 : OWN1) : IDLE;
            beat_cnt   <= '0;
            last_owner <= own_sel;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0]       m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0]       m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              busy;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM attached to the slave port: synchronous write, combinational read
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (s_we) ram[s_addr] <= s_wdata;
  assign s_rdata = ram[s_addr];

  // Reference model: expected RAM contents plus ownership bookkeeping
  logic [DATA_W-1:0] gold [0:(1<<ADDR_W)-1];
  int owner;        // -1 none, 0 = M0, 1 = M1
  int run;          // beats completed by current owner in this tenure
  int last;         // previous owner
  bit beat0, beat1;
  logic [DATA_W-1:0] rd1_seen;
  logic              swe_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    run   = 0;
    last  = 1;
  endtask

  // One bus cycle: inputs already driven at the falling edge.
  task automatic step();
    bit r[2], w[2];
    logic [31:0] a[2];
    logic [DATA_W-1:0] d[2];
    logic [DATA_W-1:0] e_rd;
    logic [ADDR_W-1:0] idx;
    bit beat, inr, e_we;
    int o, oth;
    #1;
    r[0] = m0_req; w[0] = m0_we; a[0] = m0_addr; d[0] = m0_wdata;
    r[1] = m1_req; w[1] = m1_we; a[1] = m1_addr; d[1] = m1_wdata;
    o = owner;
    beat = (o >= 0) && r[o >= 0 ? o : 0];
    check("m0_gnt", m0_gnt, o == 0);
    check("m1_gnt", m1_gnt, o == 1);
    check("busy", busy, o >= 0);
    e_we = 1'b0; e_rd = '0; idx = '0; inr = 1'b0;
    if (beat) begin
      inr  = (a[o] < (32'd1 << ADDR_W));
      idx  = a[o][ADDR_W-1:0];
      e_we = w[o] && inr;
      e_rd = (!w[o] && inr) ? gold[idx] : '0;
      check("s_addr", s_addr, idx);
      check("s_wdata", s_wdata, d[o]);
    end else begin
      check("s_addr_idle", s_addr, 0);
      check("s_wdata_idle", s_wdata, 0);
    end
    check("s_we", s_we, e_we);
    check("m0_rdata", m0_rdata, (beat && o == 0) ? e_rd : '0);
    check("m1_rdata", m1_rdata, (beat && o == 1) ? e_rd : '0);
    beat0 = beat && (o == 0);
    beat1 = beat && (o == 1);
    swe_seen = s_we;
    if (beat1) rd1_seen = m1_rdata;
    if (e_we) gold[idx] = d[o];
    // ownership for the next cycle
    if (o < 0) begin
      if (r[0] && r[1]) owner = (FIXED || last == 1) ? 0 : 1;
      else if (r[0]) owner = 0;
      else if (r[1]) owner = 1;
      run = 0;
    end else begin
      oth = 1 - o;
      if (r[o]) begin
        run++;
        if (r[oth] && run >= int'(MAX_BURST) && (!FIXED || o == 1)) begin
          last = o; owner = oth; run = 0;
        end
      end else begin
        last = o; owner = r[oth] ? oth : -1; run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_beat(input int m, input int bound);
    bit done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      step();
      done = (m == 0) ? beat0 : beat1;
    end
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a[31:ADDR_W] = 22'($urandom_range(1, 4194303));
    return a;
  endfunction

  task automatic rand_drive();
    if (!m0_req || beat0) begin
      m0_req = ($urandom_range(0, 9) < 7);
      m0_we = 1'($urandom_range(0, 1)); m0_addr = rand_addr(); m0_wdata = $urandom;
    end
    if (!m1_req || beat1) begin
      m1_req = ($urandom_range(0, 9) < 7);
      m1_we = 1'($urandom_range(0, 1)); m1_addr = rand_addr(); m1_wdata = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = '0;
      gold[i] = '0;
    end
    model_reset();
    beat0 = 0; beat1 = 0; rd1_seen = '0; swe_seen = 0;
    @(negedge clk);
    do_reset();

    // M0 write then M1 read-back
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    step();
    #1;
    check("wr_gnt_c2", m0_gnt, 1);
    check("wr_swe_c2", s_we, 1);
    check("wr_saddr_c2", s_addr, 10'h10);
    step();
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    wait_beat(1, 10);
    check("rd_back", rd1_seen, 32'hDEADBEEF);
    m1_req = 0;
    step();

    // Simultaneous requests after reset: M0 first, then M1 with no idle cycle
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    step();
    check("tie_m0_first", m0_gnt, 1);
    step();
    m0_req = 0;
    step();
    check("handover_m1", m1_gnt, 1);
    check("handover_busy", busy, 1);
    m1_req = 0;
    step();
    step();

    // Continuous contention: burst-limited alternation (or M0 holds in fixed mode)
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h3;
    m1_req = 1; m1_we = 0; m1_addr = 32'h4;
    step();
    for (int k = 0; k < 16; k++) begin
      check("burst_m0_gnt", m0_gnt, FIXED || ((k / int'(MAX_BURST)) % 2 == 0));
      step();
    end
    m0_req = 0;
    step();
    check("m0_drop_m1_gnt", m1_gnt, 1);
    m1_req = 0;
    step();
    step();

    // Out-of-range write is dropped and aliases nothing; OOB read returns 0
    m1_req = 1; m1_we = 1; m1_addr = 32'h0; m1_wdata = 32'h12345678;
    wait_beat(1, 10);
    m1_addr = 32'h400; m1_wdata = 32'hFFFFFFFF;
    wait_beat(1, 10);
    check("oob_s_we", swe_seen, 0);
    m1_we = 0; m1_addr = 32'h400;
    wait_beat(1, 10);
    check("oob_rdata", rd1_seen, 0);
    m1_addr = 32'h0;
    wait_beat(1, 10);
    check("alias_intact", rd1_seen, 32'h12345678);
    m1_req = 0;
    step();

    // Randomized traffic
    beat0 = 0; beat1 = 0;
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end
    m0_req = 0; m1_req = 0;
    step();
    step();

    // Reset asserted mid-burst while M1 owns and writes
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
    wait_beat(1, 10);
    m1_wdata = 32'h5A5A5A5A;
    #1;
    check("pre_rst_gnt", m1_gnt, 1);
    check("pre_rst_swe", s_we, 1);
    #1 reset = 1'b0;
    #1;
    check("async_m1_gnt", m1_gnt, 0);
    check("async_s_we", s_we, 0);
    @(posedge clk);
    #1;
    check("no_write_in_reset", ram[32'h20], gold[32'h20]);
    m1_req = 0; m1_we = 0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_m1_gnt", m1_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
